// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned IMEM_LATENCY = 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of tagged fetch entries; flush empties it in one cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next pointers/count; flush discards everything including a same-cycle push.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-based issue to a 1-cycle instmem, redirect squash.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              starved_q, starved_d;
    fetch_state_t      state_q, state_d;

    logic [CNT_W-1:0]  buf_count;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_entry;
    logic              pop, push, credit, issue;
    logic [OCC_W-1:0]  occupancy, limit;

    assign if_valid   = (buf_count != '0);
    assign pop        = if_valid & if_ready;
    assign push       = inflight_q & ~redirect_valid;
    assign push_entry = '{pc: req_pc_q, instr: imem_instr};
    assign imem_addr  = pc_q;
    assign if_pc      = if_valid ? buf_head.pc    : '0;
    assign if_instr   = if_valid ? buf_head.instr : '0;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Credit check, RUN/HOLD state and issue decision.
    // HOLD only arises when fetch_en or credit is already low, so gating issue
    // on the next state does not change when fetches go out.
    always_comb begin
        occupancy = OCC_W'(buf_count) + OCC_W'(inflight_q);
        limit     = OCC_W'(BUF_DEPTH) + OCC_W'(pop);
        credit    = (occupancy < limit);
        starved_d = ~credit;
        state_d   = RUN;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (!fetch_en) begin
            state_d = HOLD;
        end else if (!credit && (starved_q || state_q == HOLD)) begin
            state_d = HOLD;
        end
        issue = (state_d == RUN) & fetch_en & ~redirect_valid & credit;
    end

    // PC advance, request tag capture and in-flight tracking.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (issue) begin
            pc_d       = pc_q + ADDR_W'(4);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            starved_q  <= 1'b0;
            state_q    <= RUN;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            starved_q  <= starved_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the model is the ordered PC stream
// (restarted on reset/redirect) with instmem contents from a fixed hash.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int total  = 0;
    int bad    = 0;
    int hs_cnt = 0;

    fetch_entry_t sb_q[$];
    fetch_entry_t mon_e;
    logic [31:0]  model_next;
    logic         prev_hold = 1'b0;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0) return 32'h0020_0820;
        if (a == 32'h4) return 32'h8c0a_0000;
        h = a * 32'h9E37_79B1;
        return h ^ {a[15:0], a[31:16]};
    endfunction

    // Instruction memory with registered read.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        sb_q.delete();
        model_next = pc & 32'hFFFF_FFFC;
    endtask

    task automatic topup();
        while (sb_q.size() < 8) begin
            sb_q.push_back('{pc: model_next, instr: mem_word(model_next)});
            model_next += 32'd4;
        end
    endtask

    // Advance one clock; a reset or redirect driven in the finished cycle restarts the expected stream.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) restart(RPC);
        else if (redirect_valid) restart(redirect_pc);
        topup();
    endtask

    // Monitor: every completed handshake is compared with the head of the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, if_valid}, 32'd1);
                if (sb_q.size() != 0) check("hold_pc", if_pc, sb_q[0].pc);
            end
            if (if_valid && if_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got pc %08h expected none queued", if_pc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_pc", if_pc, mon_e.pc);
                    check("out_instr", if_instr, mon_e.instr);
                end
            end
        end
        prev_hold = !rst && if_valid && !if_ready && !redirect_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        restart(RPC);
        topup();

        // Reset state and basic streaming latency
        step(); step();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        check("c0_addr", imem_addr, 32'h0);
        step();
        check("c1_valid", {31'd0, if_valid}, 32'd0);
        check("c1_addr", imem_addr, 32'h4);
        step();
        check("c2_valid", {31'd0, if_valid}, 32'd1);
        check("c2_pc", if_pc, 32'h0);
        check("c2_instr", if_instr, 32'h0020_0820);
        check("c2_addr", imem_addr, 32'h8);
        step();
        check("c3_pc", if_pc, 32'h4);
        check("c3_instr", if_instr, 32'h8c0a_0000);
        check("c3_addr", imem_addr, 32'hC);

        // Back-pressure from the first output: two credits hold pc 0 and 4, so pc stops at 8
        rst = 1'b1; if_ready = 1'b0;
        step();
        rst = 1'b0; if_ready = 1'b1;
        step(); step();
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_pc", if_pc, 32'h0);
            check("stall_addr", imem_addr, 32'h8);
        end
        step();
        if_ready = 1'b1;
        repeat (6) step();

        // Redirect with buffered and in-flight work
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("rd1_valid", {31'd0, if_valid}, 32'd0);
        check("rd1_addr", imem_addr, 32'h40);
        step();
        check("rd2_valid", {31'd0, if_valid}, 32'd0);
        check("rd2_addr", imem_addr, 32'h44);
        step();
        check("rd3_valid", {31'd0, if_valid}, 32'd1);
        check("rd3_pc", if_pc, 32'h40);
        repeat (4) step();

        // Redirect with a same-cycle pop, then a second redirect that must win
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("rr_valid", {31'd0, if_valid}, 32'd0);
        check("rr_addr", imem_addr, 32'h100);
        step(); step();
        check("rr_pc", if_pc, 32'h100);
        repeat (4) step();

        // fetch_en low: in-flight return still buffered, then FIFO drains
        fetch_en = 1'b0; if_ready = 1'b0;
        step();
        check("fe_valid", {31'd0, if_valid}, 32'd1);
        if_ready = 1'b1;
        step(); step();
        check("fe_drained", {31'd0, if_valid}, 32'd0);
        step();
        check("fe_idle", {31'd0, if_valid}, 32'd0);
        fetch_en = 1'b1;
        repeat (6) step();

        // Reset mid-stream with data buffered and a fetch in flight
        check("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1; if_ready = 1'b0;
        step();
        rst = 1'b0; fetch_en = 1'b0;
        check("mrst_valid", {31'd0, if_valid}, 32'd0);
        check("mrst_addr", imem_addr, RPC);
        step();
        check("mrst_valid1", {31'd0, if_valid}, 32'd0);
        step();
        check("mrst_valid2", {31'd0, if_valid}, 32'd0);
        fetch_en = 1'b1; if_ready = 1'b1;
        repeat (6) step();

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step(); step();
        check("wrap0", if_pc, 32'hFFFF_FFF8);
        step();
        check("wrap1", if_pc, 32'hFFFF_FFFC);
        step();
        check("wrap2", if_pc, 32'h0000_0000);
        step();
        check("wrap3", if_pc, 32'h0000_0004);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            rst            = (r < 2);
            redirect_valid = !rst && ($urandom_range(0, 99) < 6);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            fetch_en       = ($urandom_range(0, 9) < 8);
            if_ready       = ($urandom_range(0, 9) < 6);
            step();
        end

        // Forward progress once traffic is quiet
        rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        step();
        hs0 = hs_cnt;
        repeat (12) step();
        check("progress", ((hs_cnt - hs0) >= 8) ? 32'd1 : 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
